// File: rtl/load_aligner_if.sv
// Load aligner bus bundle: request, memory read port and response channels.
interface load_aligner_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   // Block side: consumes requests and read data, produces reads and results.
   modport slave (
      input  req_valid, req_addr, req_size, req_unsigned, mem_rdata, mem_rvalid, rsp_ready,
      output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
   );

   // Environment side: memory stage, data memory and writeback.
   modport master (
      output req_valid, req_addr, req_size, req_unsigned, mem_rdata, mem_rvalid, rsp_ready,
      input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/load_aligner.sv
// Load aligner: LB/LH/LW/LBU/LHU against a word-addressed read port.
// One aligned read, or two for boundary-crossing loads, then merge/extract/extend.
module load_aligner #(
   parameter bit          SPLIT_EN = 1'b1,
   parameter int unsigned TIMEOUT  = 255
) (
   input logic          clk,
   input logic          rst_n,
   load_aligner_if.slave bus
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Abort fires on the cycle the counter would reach TIMEOUT.
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [31:0]   w0_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   rsp_data_q;
   logic          rsp_err_q;

   logic          req_bad, cap_split, in_wait, timed_out;
   logic          ld_ok, ld_err;
   logic [31:0]   w_lo, w_hi, merged, result;

   function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
      return (sz == 2'b01 && off == 2'b11) || (sz == 2'b10 && off != 2'b00);
   endfunction

   assign req_bad   = (bus.req_size == 2'b11) ||
                      (!SPLIT_EN && crosses(bus.req_size, bus.req_addr[1:0]));
   assign cap_split = crosses(size_q, addr_q[1:0]);
   assign in_wait   = (state_q == WAIT0) || (state_q == WAIT1);
   assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   // Next-state logic; ld_ok/ld_err mark the cycle a result is committed.
   always_comb begin
      state_d = state_q;
      ld_ok   = 1'b0;
      ld_err  = 1'b0;
      unique case (state_q)
         IDLE:
            if (bus.req_valid) begin
               if (req_bad) begin
                  state_d = RESP;
                  ld_err  = 1'b1;
               end else begin
                  state_d = ISSUE0;
               end
            end
         ISSUE0: state_d = WAIT0;
         WAIT0:
            if (bus.mem_rvalid) begin
               if (cap_split) begin
                  state_d = ISSUE1;
               end else begin
                  state_d = RESP;
                  ld_ok   = 1'b1;
               end
            end else if (timed_out) begin
               state_d = RESP;
               ld_err  = 1'b1;
            end
         ISSUE1: state_d = WAIT1;
         WAIT1:
            if (bus.mem_rvalid) begin
               state_d = RESP;
               ld_ok   = 1'b1;
            end else if (timed_out) begin
               state_d = RESP;
               ld_err  = 1'b1;
            end
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Merge the two words (live rdata on the final read), shift and extend.
   always_comb begin
      w_lo   = (state_q == WAIT0) ? bus.mem_rdata : w0_q;
      w_hi   = (state_q == WAIT1) ? bus.mem_rdata : 32'h0;
      merged = 32'({w_hi, w_lo} >> {addr_q[1:0], 3'b000});
      unique case (size_q)
         2'b00:   result = {{24{~uns_q & merged[7]}},  merged[7:0]};
         2'b01:   result = {{16{~uns_q & merged[15]}}, merged[15:0]};
         default: result = merged;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Timeout counter: zero outside WAIT states, counts idle WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        cnt_q <= '0;
      else if (in_wait && !bus.mem_rvalid) cnt_q <= cnt_q + 1'b1;
      else                               cnt_q <= '0;
   end

   // Request capture, first-word latch and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         w0_q       <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.req_valid) begin
            addr_q <= bus.req_addr;
            size_q <= bus.req_size;
            uns_q  <= bus.req_unsigned;
         end
         if (state_q == WAIT0 && bus.mem_rvalid) w0_q <= bus.mem_rdata;
         if (ld_ok) begin
            rsp_data_q <= result;
            rsp_err_q  <= 1'b0;
         end else if (ld_err) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.mem_rd    = (state_q == ISSUE0) || (state_q == ISSUE1);
   // Second word address wraps naturally in the 30-bit word index.
   assign bus.mem_addr  = (state_q == ISSUE0) ? {addr_q[31:2], 2'b00} :
                          (state_q == ISSUE1) ? {addr_q[31:2] + 30'd1, 2'b00} : 32'h0;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule
